// File: rtl/modrm_operand_decoder_if.sv
// Handshake bundle between the opcode decoder, the instruction byte stream,
// and the consumer of decoded ModRM/SIB/disp/imm operand fields.
interface modrm_operand_decoder_if #(parameter int OUT_W = 64);
  logic             start_valid;
  logic             start_ready;
  logic             start_has_modrm;
  logic [3:0]       start_rex;
  logic [3:0]       start_imm_bytes;
  logic             byte_valid;
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_reg_id;
  logic             out_rm_is_mem;
  logic [3:0]       out_base_reg;
  logic [3:0]       out_index_reg;
  logic [1:0]       out_scale;
  logic             out_has_base;
  logic             out_has_index;
  logic             out_has_disp;
  logic             out_rip_relative;
  logic [OUT_W-1:0] out_disp;
  logic             out_has_imm;
  logic [OUT_W-1:0] out_imm;
  logic [3:0]       out_len;

  modport slave (
    input  start_valid, start_has_modrm, start_rex, start_imm_bytes,
           byte_valid, byte_data, out_ready,
    output start_ready, byte_ready, out_valid, out_reg_id, out_rm_is_mem,
           out_base_reg, out_index_reg, out_scale, out_has_base, out_has_index,
           out_has_disp, out_rip_relative, out_disp, out_has_imm, out_imm, out_len
  );

  modport master (
    output start_valid, start_has_modrm, start_rex, start_imm_bytes,
           byte_valid, byte_data, out_ready,
    input  start_ready, byte_ready, out_valid, out_reg_id, out_rm_is_mem,
           out_base_reg, out_index_reg, out_scale, out_has_base, out_has_index,
           out_has_disp, out_rip_relative, out_disp, out_has_imm, out_imm, out_len
  );
endinterface

// File: rtl/modrm_operand_decoder.sv
// Byte-serial decoder for the x86-64 ModRM/SIB/displacement/immediate tail,
// producing register, r/m (reg, mem, RIP-relative) and immediate fields.
module modrm_operand_decoder #(
  parameter int OUT_W         = 64,
  parameter int MAX_IMM_BYTES = 8
) (
  input logic                   clk,
  input logic                   reset,
  modrm_operand_decoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MODRM, SIB, DISP, IMM, DONE} state_t;

  state_t      state, tgt;
  logic [3:0]  rex_q, imm_len, disp_len, cnt, imm_n, dl_modrm, dl_sib, dl_sel;
  logic [1:0]  mod_q;
  logic [63:0] acc, acc_nx;
  logic        take, go, to_sib, last;

  wire [1:0] b_mod = bus.byte_data[7:6];
  wire [2:0] b_rm  = bus.byte_data[2:0];

  function automatic logic [3:0] norm_imm(input logic [3:0] n);
    if ((n == 4'd0 || n == 4'd1 || n == 4'd2 || n == 4'd4 || n == 4'd8) &&
        32'(n) <= MAX_IMM_BYTES)
      return n;
    return 4'(MAX_IMM_BYTES);
  endfunction

  function automatic logic [3:0] dmod(input logic [1:0] m);
    return (m == 2'd1) ? 4'd1 : (m == 2'd2) ? 4'd4 : 4'd0;
  endfunction

  function automatic logic [OUT_W-1:0] sext(input logic [63:0] v, input logic [3:0] n);
    case (n)
      4'd1:    return OUT_W'($signed(v[7:0]));
      4'd2:    return OUT_W'($signed(v[15:0]));
      4'd4:    return OUT_W'($signed(v[31:0]));
      default: return OUT_W'($signed(v));
    endcase
  endfunction

  assign bus.start_ready = (state == IDLE);
  assign bus.byte_ready  = (state == MODRM) || (state == SIB) || (state == DISP) || (state == IMM);
  assign take            = bus.byte_valid && bus.byte_ready;
  assign imm_n           = norm_imm(bus.start_imm_bytes);

  // rm=101 with mod=00 is RIP-relative with a forced disp32; in SIB it means "no base"
  assign dl_modrm = (b_mod == 2'd0 && b_rm == 3'd5) ? 4'd4 : dmod(b_mod);
  assign dl_sib   = (b_rm == 3'd5 && mod_q == 2'd0) ? 4'd4 : dmod(mod_q);
  assign dl_sel   = (state == SIB) ? dl_sib : dl_modrm;
  assign to_sib   = (b_mod != 2'd3) && (b_rm == 3'd4);
  assign last     = (cnt == (((state == DISP) ? disp_len : imm_len) - 4'd1));

  always_comb begin
    acc_nx = acc;
    acc_nx[{cnt[2:0], 3'b000} +: 8] = bus.byte_data;
  end

  always_comb begin
    tgt = DONE;
    go  = 1'b0;
    case (state)
      IDLE: begin
        tgt = bus.start_has_modrm ? MODRM : (imm_n != 4'd0) ? IMM : DONE;
        go  = bus.start_valid;
      end
      MODRM, SIB: begin
        tgt = (dl_sel != 4'd0) ? DISP : (imm_len != 4'd0) ? IMM : DONE;
        go  = take && !(state == MODRM && to_sib);
      end
      DISP: begin
        tgt = (imm_len != 4'd0) ? IMM : DONE;
        go  = take && last;
      end
      IMM: begin
        tgt = DONE;
        go  = take && last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rex_q                <= '0;
      imm_len              <= '0;
      disp_len             <= '0;
      mod_q                <= '0;
      cnt                  <= '0;
      acc                  <= '0;
      bus.out_valid        <= 1'b0;
      bus.out_reg_id       <= '0;
      bus.out_rm_is_mem    <= 1'b0;
      bus.out_base_reg     <= '0;
      bus.out_index_reg    <= '0;
      bus.out_scale        <= '0;
      bus.out_has_base     <= 1'b0;
      bus.out_has_index    <= 1'b0;
      bus.out_has_disp     <= 1'b0;
      bus.out_rip_relative <= 1'b0;
      bus.out_disp         <= '0;
      bus.out_has_imm      <= 1'b0;
      bus.out_imm          <= '0;
      bus.out_len          <= '0;
    end else begin
      if (take) bus.out_len <= bus.out_len + 4'd1;
      case (state)
        IDLE: if (bus.start_valid) begin
          rex_q                <= bus.start_rex;
          imm_len              <= imm_n;
          bus.out_reg_id       <= '0;
          bus.out_rm_is_mem    <= 1'b0;
          bus.out_base_reg     <= '0;
          bus.out_index_reg    <= '0;
          bus.out_scale        <= '0;
          bus.out_has_base     <= 1'b0;
          bus.out_has_index    <= 1'b0;
          bus.out_has_disp     <= 1'b0;
          bus.out_rip_relative <= 1'b0;
          bus.out_disp         <= '0;
          bus.out_has_imm      <= 1'b0;
          bus.out_imm          <= '0;
          bus.out_len          <= '0;
        end
        MODRM: if (take) begin
          bus.out_reg_id    <= {rex_q[2], bus.byte_data[5:3]};
          bus.out_rm_is_mem <= (b_mod != 2'd3);
          mod_q             <= b_mod;
          disp_len          <= dl_modrm;
          if (to_sib) begin
            state <= SIB;
          end else if (b_mod == 2'd0 && b_rm == 3'd5) begin
            bus.out_rip_relative <= 1'b1;
            bus.out_has_base     <= 1'b0;
          end else begin
            bus.out_base_reg <= {rex_q[0], b_rm};
            bus.out_has_base <= 1'b1;
          end
        end
        SIB: if (take) begin
          bus.out_scale     <= b_mod;
          bus.out_index_reg <= {rex_q[1], bus.byte_data[5:3]};
          bus.out_has_index <= !(rex_q[1] == 1'b0 && bus.byte_data[5:3] == 3'd4);
          disp_len          <= dl_sib;
          if (b_rm == 3'd5 && mod_q == 2'd0) begin
            bus.out_has_base <= 1'b0;
          end else begin
            bus.out_base_reg <= {rex_q[0], b_rm};
            bus.out_has_base <= 1'b1;
          end
        end
        DISP, IMM: if (take) begin
          acc <= acc_nx;
          cnt <= cnt + 4'd1;
          if (last && state == DISP) bus.out_disp <= sext(acc_nx, disp_len);
          if (last && state == IMM)  bus.out_imm  <= sext(acc_nx, imm_len);
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Common entry actions for the next field; overrides the per-state updates above
      if (go) begin
        state <= tgt;
        cnt   <= '0;
        acc   <= '0;
        if (tgt == DISP) bus.out_has_disp <= 1'b1;
        if (tgt == IMM)  bus.out_has_imm  <= 1'b1;
        if (tgt == DONE) bus.out_valid    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_modrm_operand_decoder.sv
// Directed bench for modrm_operand_decoder: hand-computed operand tails,
// stalls on both handshakes, zero-length and illegal-immediate starts, mid-decode reset.
module tb_modrm_operand_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  modrm_operand_decoder_if #(.OUT_W(64)) bus ();

  modrm_operand_decoder #(.OUT_W(64), .MAX_IMM_BYTES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic hm, input logic [3:0] rex, input logic [3:0] imm);
    int n = 0;
    while (!bus.start_ready && n < 20) begin tick(); n++; end
    if (!bus.start_ready) chk("start_ready_timeout", 64'(bus.start_ready), 1);
    bus.start_valid     = 1'b1;
    bus.start_has_modrm = hm;
    bus.start_rex       = rex;
    bus.start_imm_bytes = imm;
    tick();
    bus.start_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!bus.byte_ready && n < 20) begin tick(); n++; end
    if (!bus.byte_ready) chk("byte_ready_timeout", 64'(bus.byte_ready), 1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 1);
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 0);
    chk("start_ready_back", 64'(bus.start_ready), 1);
  endtask

  task automatic case_rip();
    start(1'b1, 4'b0000, 4'd0);
    send(8'h05); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    chk("rip_valid", 64'(bus.out_valid), 1);
    chk("rip_rel", 64'(bus.out_rip_relative), 1);
    chk("rip_has_base", 64'(bus.out_has_base), 0);
    chk("rip_has_disp", 64'(bus.out_has_disp), 1);
    chk("rip_disp", bus.out_disp, 64'h10);
    chk("rip_len", 64'(bus.out_len), 5);
    finish_out();
  endtask

  initial begin
    bus.start_valid = 0; bus.start_has_modrm = 0; bus.start_rex = 0; bus.start_imm_bytes = 0;
    bus.byte_valid = 0; bus.byte_data = 0; bus.out_ready = 0;
    tick(); tick();
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_start_ready", 64'(bus.start_ready), 1);
    chk("rst_len", 64'(bus.out_len), 0);
    reset = 1'b0;
    tick();

    // register-direct with REX.B
    start(1'b1, 4'b0001, 4'd0);
    chk("c1_not_yet", 64'(bus.out_valid), 0);
    send(8'hC8);
    chk("c1_latency", 64'(bus.out_valid), 1);
    chk("c1_reg_id", 64'(bus.out_reg_id), 1);
    chk("c1_rm_mem", 64'(bus.out_rm_is_mem), 0);
    chk("c1_base", 64'(bus.out_base_reg), 8);
    chk("c1_len", 64'(bus.out_len), 1);
    finish_out();

    case_rip();

    // SIB with disp8
    start(1'b1, 4'b0000, 4'd0);
    send(8'h44); send(8'h88); send(8'hF8);
    wait_out();
    chk("c3_base", 64'(bus.out_base_reg), 0);
    chk("c3_index", 64'(bus.out_index_reg), 1);
    chk("c3_scale", 64'(bus.out_scale), 2);
    chk("c3_has_index", 64'(bus.out_has_index), 1);
    chk("c3_disp", bus.out_disp, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("c3_len", 64'(bus.out_len), 3);
    finish_out();

    // SIB no-base, no-index, then with REX.X
    start(1'b1, 4'b0000, 4'd0);
    send(8'h04); send(8'h25); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_out();
    chk("c4_has_base", 64'(bus.out_has_base), 0);
    chk("c4_has_index", 64'(bus.out_has_index), 0);
    chk("c4_disp", bus.out_disp, 64'h1234_5678);
    chk("c4_len", 64'(bus.out_len), 6);
    finish_out();
    start(1'b1, 4'b0010, 4'd0);
    send(8'h04); send(8'h25); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_out();
    chk("c4x_has_index", 64'(bus.out_has_index), 1);
    chk("c4x_index", 64'(bus.out_index_reg), 12);
    chk("c4x_disp", bus.out_disp, 64'h1234_5678);
    finish_out();

    // imm32 with byte gaps and consumer stall
    start(1'b1, 4'b0000, 4'd4);
    send(8'hC0); tick();
    send(8'hFF); tick();
    send(8'hFF); tick();
    send(8'hFF); tick();
    chk("c5_len_mid", 64'(bus.out_len), 4);
    send(8'h7F);
    for (int i = 0; i < 3; i++) begin
      chk("c5_hold_valid", 64'(bus.out_valid), 1);
      chk("c5_hold_imm", bus.out_imm, 64'h7FFF_FFFF);
      tick();
    end
    chk("c5_has_imm", 64'(bus.out_has_imm), 1);
    chk("c5_len", 64'(bus.out_len), 5);
    finish_out();

    // zero-length start
    start(1'b0, 4'b0000, 4'd0);
    chk("z_valid", 64'(bus.out_valid), 1);
    chk("z_len", 64'(bus.out_len), 0);
    chk("z_has_imm", 64'(bus.out_has_imm), 0);
    finish_out();

    // imm16 negative, no ModRM
    start(1'b0, 4'b0000, 4'd2);
    send(8'h34); send(8'hF2);
    chk("i2_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_F234);
    chk("i2_len", 64'(bus.out_len), 2);
    finish_out();

    // illegal size 3 decodes as imm64
    start(1'b0, 4'b0000, 4'd3);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h00);
    chk("i3_not_yet", 64'(bus.out_valid), 0);
    send(8'h80);
    chk("i3_imm", bus.out_imm, 64'h8000_0000_0000_0001);
    chk("i3_len", 64'(bus.out_len), 8);
    finish_out();

    // reset after 2 of 5 bytes, then a clean decode
    start(1'b1, 4'b0000, 4'd0);
    send(8'h05); send(8'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_start_ready", 64'(bus.start_ready), 1);
    chk("mr_byte_ready", 64'(bus.byte_ready), 0);
    chk("mr_out_valid", 64'(bus.out_valid), 0);
    chk("mr_len", 64'(bus.out_len), 0);
    case_rip();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
